entry_ctrl: RTL and testbench

Operand-entry sequencer for the hex calculator datapath. Consumes decoded keypad events and drives the write-enable and clear strobes of the two 8-bit digit-accumulating operand registers (A and B). It also latches the selected operation, starts the ALU and selects what the display shows. It sits between the keypad decoder and the operand registers/ALU.

---
 rtl/entry_pkg.sv | 35 +++
 rtl/entry_key_decode.sv | 18 +
 rtl/entry_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_entry_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared types and encodings for the operand-entry sequencer.
package entry_pkg;

    typedef enum logic [2:0] {
        S_A      = 3'd0,
        S_B      = 3'd1,
        S_CALC   = 3'd2,
        S_WAIT   = 3'd3,
        S_SHOW   = 3'd4,
        S_RELOAD = 3'd5
    } entry_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam logic [3:0] CMD_ADD = 4'h0;
    localparam logic [3:0] CMD_SUB = 4'h1;
    localparam logic [3:0] CMD_EQ  = 4'h2;
    localparam logic [3:0] CMD_CLR = 4'h3;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;

    function automatic logic [1:0] disp_of(input entry_state_t s);
        case (s)
            S_B:                    return DISP_B;
            S_CALC, S_WAIT, S_SHOW: return DISP_RES;
            default:                return DISP_A;
        endcase
    endfunction

endpackage

// File: rtl/entry_key_decode.sv
// Combinational classification of a keypad event into digit / op / equals / clear.
module entry_key_decode
    import entry_pkg::*;
(
    input  logic       key_is_cmd,
    input  logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr
);

    assign is_digit = !key_is_cmd;
    assign is_op    = key_is_cmd && ((key_code == CMD_ADD) || (key_code == CMD_SUB));
    assign is_eq    = key_is_cmd && (key_code == CMD_EQ);
    assign is_clr   = key_is_cmd && (key_code == CMD_CLR);

endmodule

// File: rtl/entry_ctrl.sv
// Operand-entry sequencer: keypad events -> operand register strobes, ALU start, display select.
// Optional ENTRY_CTRL_AUTO_ADVANCE_EN: a full operand A moves entry to B without an op key.
//
// state    | meaning
// S_A      | entering operand A
// S_B      | entering operand B
// S_CALC   | issue ALU start
// S_WAIT   | await ALU result
// S_SHOW   | result displayed
// S_RELOAD | write the digit captured in S_SHOW into A
module entry_ctrl
    import entry_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic       key_is_cmd,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       calc_done,
    output logic [3:0] digit_out,
    output logic       a_write_en,
    output logic       b_write_en,
    output logic       a_clear,
    output logic       b_clear,
    output logic       op_sel,
    output logic       calc_start,
    output logic [1:0] disp_sel,
    output logic       overflow
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] DMAX = DW'(MAX_DIGITS);

    entry_state_t  state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    digit_q, digit_d;
    op_t           op_q, op_d;
    logic          ready_q, ready_d;
    logic [1:0]    disp_q, disp_d;
    logic          a_we_q, a_we_d, b_we_q, b_we_d;
    logic          a_clr_q, a_clr_d, b_clr_q, b_clr_d;
    logic          start_q, start_d, ovf_q, ovf_d;

    logic is_digit, is_op, is_eq, is_clr, accept;

    entry_key_decode u_dec (
        .key_is_cmd (key_is_cmd),
        .key_code   (key_code),
        .is_digit   (is_digit),
        .is_op      (is_op),
        .is_eq      (is_eq),
        .is_clr     (is_clr)
    );

    // Keys arriving while key_ready is low are dropped, CLEAR included.
    assign accept = key_valid && ready_q;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        pend_d  = pend_q;
        digit_d = digit_q;
        op_d    = op_q;
        a_we_d  = 1'b0;
        b_we_d  = 1'b0;
        a_clr_d = 1'b0;
        b_clr_d = 1'b0;
        start_d = 1'b0;
        ovf_d   = 1'b0;

        if (accept && is_clr) begin
            a_clr_d = 1'b1;
            b_clr_d = 1'b1;
            dcnt_d  = '0;
            state_d = S_A;
        end else begin
            case (state_q)
                S_A, S_B: begin
                    if (accept && is_digit) begin
                        if (dcnt_q < DMAX) begin
                            digit_d = key_code;
                            dcnt_d  = dcnt_q + DW'(1);
                            if (state_q == S_A) a_we_d = 1'b1;
                            else                b_we_d = 1'b1;
`ifdef ENTRY_CTRL_AUTO_ADVANCE_EN
                            if ((state_q == S_A) && (dcnt_q == DMAX - DW'(1))) begin
                                dcnt_d  = '0;
                                b_clr_d = 1'b1;
                                state_d = S_B;
                            end
`endif
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (accept && is_op) begin
                        if (state_q == S_B) begin
                            op_d = op_t'(key_code[0]);
                        end else if (dcnt_q != '0) begin
                            op_d    = op_t'(key_code[0]);
                            b_clr_d = 1'b1;
                            dcnt_d  = '0;
                            state_d = S_B;
                        end
                    end else if (accept && is_eq && (state_q == S_B) && (dcnt_q != '0)) begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (calc_done) state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (accept && is_digit) begin
                        pend_d  = key_code;
                        a_clr_d = 1'b1;
                        b_clr_d = 1'b1;
                        state_d = S_RELOAD;
                    end
                end
                S_RELOAD: begin
                    a_we_d  = 1'b1;
                    digit_d = pend_q;
                    dcnt_d  = DW'(1);
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end

        ready_d = (state_d != S_CALC) && (state_d != S_RELOAD);
        disp_d  = disp_of(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_A;
            dcnt_q  <= '0;
            pend_q  <= '0;
            digit_q <= '0;
            op_q    <= OP_ADD;
            ready_q <= 1'b1;
            disp_q  <= DISP_A;
            a_we_q  <= 1'b0;
            b_we_q  <= 1'b0;
            a_clr_q <= 1'b0;
            b_clr_q <= 1'b0;
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
            digit_q <= digit_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            disp_q  <= disp_d;
            a_we_q  <= a_we_d;
            b_we_q  <= b_we_d;
            a_clr_q <= a_clr_d;
            b_clr_q <= b_clr_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_ready  = ready_q;
    assign digit_out  = digit_q;
    assign a_write_en = a_we_q;
    assign b_write_en = b_we_q;
    assign a_clear    = a_clr_q;
    assign b_clear    = b_clr_q;
    assign op_sel     = op_q;
    assign calc_start = start_q;
    assign disp_sel   = disp_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_entry_ctrl.sv
// Bench for entry_ctrl: directed scenarios then random keys, every cycle checked against a reference model.
module tb_entry_ctrl;

    localparam int MAXD = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_is_cmd = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       calc_done = 1'b0;
    logic       key_ready, a_write_en, b_write_en, a_clear, b_clear, op_sel, calc_start, overflow;
    logic [3:0] digit_out;
    logic [1:0] disp_sel;

    int n_assert = 0;
    int n_fail   = 0;

    entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_is_cmd (key_is_cmd),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .calc_done  (calc_done),
        .digit_out  (digit_out),
        .a_write_en (a_write_en),
        .b_write_en (b_write_en),
        .a_clear    (a_clear),
        .b_clear    (b_clear),
        .op_sel     (op_sel),
        .calc_start (calc_start),
        .disp_sel   (disp_sel),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: which operand is being entered, how many digits it holds, and what happens next.
    localparam int ENTER_A = 0, ENTER_B = 1, STARTING = 2, BUSY = 3, SHOWING = 4, RELOADING = 5;
    int         m_mode;
    int         m_count;
    logic       m_op;
    logic [3:0] m_pend;
    logic [3:0] m_digit;
    logic       e_rdy, e_awe, e_bwe, e_aclr, e_bclr, e_start, e_ovf;
    logic [1:0] e_disp;

    function automatic logic [1:0] disp_for(input int mode);
        if (mode == ENTER_B) return 2'd1;
        if (mode == ENTER_A || mode == RELOADING) return 2'd0;
        return 2'd2;
    endfunction

    task automatic model_reset();
        m_mode = ENTER_A; m_count = 0; m_op = 1'b0; m_pend = 4'h0; m_digit = 4'h0;
        e_rdy = 1'b1; e_disp = 2'd0;
        e_awe = 0; e_bwe = 0; e_aclr = 0; e_bclr = 0; e_start = 0; e_ovf = 0;
    endtask

    task automatic model_step(input logic kv, input logic cmd, input logic [3:0] code, input logic done);
        logic taken;
        taken = kv && e_rdy;
        e_awe = 0; e_bwe = 0; e_aclr = 0; e_bclr = 0; e_start = 0; e_ovf = 0;
        if (taken && cmd && code == 4'd3) begin
            e_aclr = 1; e_bclr = 1;
            m_mode = ENTER_A; m_count = 0;
        end else if (m_mode == ENTER_A || m_mode == ENTER_B) begin
            if (taken && !cmd) begin
                if (m_count >= MAXD) begin
                    e_ovf = 1;
                end else begin
                    m_count = m_count + 1;
                    m_digit = code;
                    if (m_mode == ENTER_A) e_awe = 1; else e_bwe = 1;
`ifdef ENTRY_CTRL_AUTO_ADVANCE_EN
                    if (m_mode == ENTER_A && m_count == MAXD) begin
                        m_mode = ENTER_B; m_count = 0; e_bclr = 1;
                    end
`endif
                end
            end else if (taken && cmd && code <= 4'd1) begin
                if (m_mode == ENTER_B) begin
                    m_op = code[0];
                end else if (m_count > 0) begin
                    m_op = code[0]; e_bclr = 1; m_count = 0; m_mode = ENTER_B;
                end
            end else if (taken && cmd && code == 4'd2 && m_mode == ENTER_B && m_count > 0) begin
                m_mode = STARTING;
            end
        end else if (m_mode == STARTING) begin
            e_start = 1; m_mode = BUSY;
        end else if (m_mode == BUSY) begin
            if (done) m_mode = SHOWING;
        end else if (m_mode == SHOWING) begin
            if (taken && !cmd) begin
                m_pend = code; e_aclr = 1; e_bclr = 1; m_mode = RELOADING;
            end
        end else begin
            e_awe = 1; m_digit = m_pend; m_count = 1; m_mode = ENTER_A;
        end
        e_rdy  = !(m_mode == STARTING || m_mode == RELOADING);
        e_disp = disp_for(m_mode);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("key_ready",  {3'b0, key_ready},  {3'b0, e_rdy});
        chk("disp_sel",   {2'b0, disp_sel},   {2'b0, e_disp});
        chk("a_write_en", {3'b0, a_write_en}, {3'b0, e_awe});
        chk("b_write_en", {3'b0, b_write_en}, {3'b0, e_bwe});
        chk("a_clear",    {3'b0, a_clear},    {3'b0, e_aclr});
        chk("b_clear",    {3'b0, b_clear},    {3'b0, e_bclr});
        chk("op_sel",     {3'b0, op_sel},     {3'b0, m_op});
        chk("calc_start", {3'b0, calc_start}, {3'b0, e_start});
        chk("overflow",   {3'b0, overflow},   {3'b0, e_ovf});
        if (e_awe || e_bwe) chk("digit_out", digit_out, m_digit);
        chk("a_we_and_clr", {3'b0, a_write_en && a_clear}, 4'h0);
        chk("b_we_and_clr", {3'b0, b_write_en && b_clear}, 4'h0);
    endtask

    // Drive one cycle of inputs (already at a negedge), clock it, check at the next negedge.
    task automatic cyc(input logic kv, input logic cmd, input logic [3:0] code, input logic done);
        key_valid = kv; key_is_cmd = cmd; key_code = code; calc_done = done;
        model_step(kv, cmd, code, done);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic dig(input logic [3:0] d);
        cyc(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic cmd_key(input logic [3:0] c);
        cyc(1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        key_valid = 1'b0; calc_done = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_digit_out", digit_out, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("reset_digit_out", digit_out, 4'h0);
        reset_n = 1'b1;
        idle(1);

        // Entry and calculate: 3 7 ADD 1 = then done
        dig(4'h3); dig(4'h7); cmd_key(4'h0); dig(4'h1); cmd_key(4'h2);
        idle(3);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        idle(2);

        // Digit limit and ignored keys in S_A
        cmd_key(4'h3);
        cmd_key(4'h2); cmd_key(4'h0);
        dig(4'h1); dig(4'h2); dig(4'h4);
        dig(4'h5); dig(4'h6);
        cmd_key(4'h1); cmd_key(4'h2); dig(4'h8); dig(4'h9); dig(4'hA);
        cmd_key(4'h0); cmd_key(4'h2);

        // Clear during S_WAIT, then a late calc_done is ignored
        idle(2);
        cmd_key(4'h3);
        idle(2);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        idle(1);

        // Reach S_SHOW, restart with 0xC, key in the not-ready cycle is dropped
        dig(4'h2); cmd_key(4'h1); dig(4'h4); cmd_key(4'h2);
        idle(2);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cmd_key(4'h2); cmd_key(4'h0); cmd_key(4'hF);
        dig(4'hC);
        dig(4'h5);
        idle(1);
        dig(4'h7);

        // Reset in S_WAIT and in S_RELOAD
        cmd_key(4'h0); dig(4'h3); cmd_key(4'h2);
        idle(2);
        async_reset();
        idle(1);
        dig(4'h1); cmd_key(4'h0); dig(4'h2); cmd_key(4'h2);
        idle(2);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        dig(4'hE);
        async_reset();
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       kv, cmd, dn;
            logic [3:0] code;
            kv  = ($urandom_range(0, 2) == 0);
            cmd = ($urandom_range(0, 1) == 0);
            if (cmd) begin
                code = (($urandom_range(0, 9) == 0) ? 4'(($urandom_range(4, 15))) : 4'(($urandom_range(0, 2))));
                if ($urandom_range(0, 12) == 0) code = 4'h3;
            end else begin
                code = 4'($urandom_range(0, 15));
            end
            dn = ($urandom_range(0, 5) == 0);
            cyc(kv, cmd, code, dn);
            if ($urandom_range(0, 400) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
